// File: rtl/majority_bist.sv
// BIST sequencer for a 4-input majority voter: steps all 16 input vectors,
// samples the voter after a settle time and records pass, mismatch count and first failing vector.
module majority_bist #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned THRESH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_out,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] fail_count,
  output logic [3:0] first_fail_vec,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] THRESH_W    = 3'(THRESH);

  state_t     state_q, state_d;
  logic [3:0] index_q, index_d;
  logic [3:0] settle_q, settle_d;
  logic [3:0] vec_q, vec_d;
  logic       pass_q, pass_d;
  logic [4:0] fail_q, fail_d;
  logic [3:0] ffv_q, ffv_d;

  logic [2:0] ones;
  logic       expected;
  logic       mismatch;

  assign ones     = 3'(index_q[3]) + 3'(index_q[2]) + 3'(index_q[1]) + 3'(index_q[0]);
  assign expected = (ones >= THRESH_W);
  assign mismatch = (dut_out != expected);

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    ffv_d    = ffv_q;
    unique case (state_q)
      IDLE: begin
        vec_d = 4'd0;
        if (start) begin
          state_d  = APPLY;
          index_d  = 4'd0;
          settle_d = 4'd0;
          fail_d   = 5'd0;
          ffv_d    = 4'd0;
          pass_d   = 1'b0;
        end
      end
      APPLY: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mismatch) begin
          fail_d = fail_q + 5'd1;
          if (fail_q == 5'd0) begin
            ffv_d = index_q;
          end
        end
        // The run ends on the last vector rather than letting the index wrap.
        if (index_q == 4'd15) begin
          state_d = DONE;
          vec_d   = 4'd0;
          pass_d  = (fail_d == 5'd0);
        end else begin
          state_d  = APPLY;
          index_d  = index_q + 4'd1;
          settle_d = 4'd0;
          vec_d    = index_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= 4'd0;
      settle_q <= 4'd0;
      vec_q    <= 4'd0;
      pass_q   <= 1'b0;
      fail_q   <= 5'd0;
      ffv_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffv_q    <= ffv_d;
    end
  end

  assign {a, b, c, d}   = vec_q;
  assign busy           = (state_q == APPLY) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign fail_count     = fail_q;
  assign first_fail_vec = ffv_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_majority_bist.sv
// Bench for majority_bist: two instances (SETTLE=1 and SETTLE=3) driven by a behavioural voter
// with selectable faults; expected vectors and run results are queued and checked by monitors.
module tb_majority_bist;

  localparam int RW = 26;  // {pass, fail_count[4:0], first_fail_vec[3:0], done_edge[15:0]}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam int NO_EDGE = 1000;

  logic clk = 1'b0;
  logic reset;
  logic start1, start3;
  int   mode1, mode3;
  logic dut_out1, dut_out3;
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic a3, b3, c3, d3, busy3, done3, pass3;
  logic [4:0] fc1, fc3;
  logic [3:0] ffv1, ffv3;
  logic [1:0] st1, st3;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [3:0]    exp_vec1_q[$];
  logic [3:0]    exp_vec3_q[$];
  logic [RW-1:0] exp_res1_q[$];
  logic [RW-1:0] exp_res3_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- voter model with fault modes ----------------
  // 0: correct majority, 1: stuck 0, 2: stuck 1, 3: 4-input OR
  function automatic logic voter(input int mode, input logic [3:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(v[i]);
    case (mode)
      0:       return (ones >= 3);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (v != 4'd0);
    endcase
  endfunction

  assign dut_out1 = voter(mode1, {a1, b1, c1, d1});
  assign dut_out3 = voter(mode3, {a3, b3, c3, d3});

  majority_bist #(.SETTLE(1), .THRESH(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .dut_out(dut_out1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_vec(ffv1), .dbg_state_o(st1)
  );

  majority_bist #(.SETTLE(3), .THRESH(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .dut_out(dut_out3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_count(fc3), .first_fail_vec(ffv3), .dbg_state_o(st3)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic check_idle(input int sel);
    if (sel == 1) begin
      check("idle1_abcd", {a1, b1, c1, d1}, 0);
      check("idle1_busy", busy1, 0);
      check("idle1_done", done1, 0);
      check("idle1_pass", pass1, 0);
      check("idle1_fc", fc1, 0);
      check("idle1_ffv", ffv1, 0);
      check("idle1_state", st1, ST_IDLE);
    end else begin
      check("idle3_abcd", {a3, b3, c3, d3}, 0);
      check("idle3_busy", busy3, 0);
      check("idle3_done", done3, 0);
      check("idle3_pass", pass3, 0);
      check("idle3_fc", fc3, 0);
      check("idle3_ffv", ffv3, 0);
      check("idle3_state", st3, ST_IDLE);
    end
  endtask

  function automatic int pending(input int sel);
    if (sel == 1) return exp_vec1_q.size() + exp_res1_q.size();
    return exp_vec3_q.size() + exp_res3_q.size();
  endfunction

  task automatic flush(input int sel);
    if (sel == 1) begin exp_vec1_q.delete(); exp_res1_q.delete(); end
    else begin exp_vec3_q.delete(); exp_res3_q.delete(); end
  endtask

  // ---------------- driver ----------------
  // Start pulse lands on edge E0; optional extra start pulse and reset pulse at given edge offsets.
  task automatic run_dut(input int sel, input int settle, input int mode,
                         input logic ep, input logic [4:0] efc, input logic [3:0] effv,
                         input int extra_start, input int reset_edge);
    int e0, span;
    span = 16 * (settle + 1);
    @(negedge clk);
    e0 = cyc + 1;
    if (sel == 1) begin mode1 = mode; start1 = 1'b1; end
    else begin mode3 = mode; start3 = 1'b1; end
    for (int k = 0; k < span; k++) begin
      if (sel == 1) exp_vec1_q.push_back(4'(k / (settle + 1)));
      else exp_vec3_q.push_back(4'(k / (settle + 1)));
    end
    if (sel == 1) exp_res1_q.push_back({ep, efc, effv, 16'(e0 + span)});
    else exp_res3_q.push_back({ep, efc, effv, 16'(e0 + span)});
    for (int k = 0; k <= span; k++) begin
      @(negedge clk);
      if (sel == 1) start1 = (k + 1 == extra_start);
      else start3 = (k + 1 == extra_start);
      reset = (k + 1 == reset_edge);
      if (k == reset_edge) flush(sel);
      if (k == reset_edge + 1) begin
        check_idle(sel);
        break;
      end
    end
    for (int t = 0; t < 200 && pending(sel) != 0; t++) @(negedge clk);
    if (pending(sel) != 0) begin
      n_checks++;
      $display("FAIL run%0d_timeout: %0d expected responses still queued, required 0", sel, pending(sel));
      flush(sel);
    end
    repeat (3) @(negedge clk);
    if (reset_edge == NO_EDGE) begin
      if (sel == 1) begin
        check("hold1_fc", fc1, efc);
        check("hold1_pass", pass1, ep);
        check("hold1_state", st1, ST_IDLE);
      end else begin
        check("hold3_fc", fc3, efc);
        check("hold3_pass", pass3, ep);
        check("hold3_state", st3, ST_IDLE);
      end
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [3:0]    v;
    logic [RW-1:0] r;
    if (busy1) begin
      if (exp_vec1_q.size() == 0) check("busy1_unexpected", busy1, 0);
      else begin
        v = exp_vec1_q.pop_front();
        check("vec1", {a1, b1, c1, d1}, v);
      end
    end
    if (done1) begin
      if (exp_res1_q.size() == 0) check("done1_unexpected", done1, 0);
      else begin
        r = exp_res1_q.pop_front();
        check("res1_pass", pass1, r[25]);
        check("res1_fail_count", fc1, r[24:20]);
        check("res1_first_fail_vec", ffv1, r[19:16]);
        check("res1_done_edge", cyc, r[15:0]);
        check("res1_abcd_in_done", {a1, b1, c1, d1}, 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0]    v;
    logic [RW-1:0] r;
    if (busy3) begin
      if (exp_vec3_q.size() == 0) check("busy3_unexpected", busy3, 0);
      else begin
        v = exp_vec3_q.pop_front();
        check("vec3", {a3, b3, c3, d3}, v);
      end
    end
    if (done3) begin
      if (exp_res3_q.size() == 0) check("done3_unexpected", done3, 0);
      else begin
        r = exp_res3_q.pop_front();
        check("res3_pass", pass3, r[25]);
        check("res3_fail_count", fc3, r[24:20]);
        check("res3_first_fail_vec", ffv3, r[19:16]);
        check("res3_done_edge", cyc, r[15:0]);
        check("res3_abcd_in_done", {a3, b3, c3, d3}, 0);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1 = 0;
    mode3 = 0;
    repeat (3) @(negedge clk);
    check_idle(1);
    check_idle(3);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // correct voter: no mismatches
    run_dut(1, 1, 0, 1'b1, 5'd0, 4'd0, NO_EDGE, NO_EDGE);
    // stuck-0: misses the five vectors with >= 3 ones, first is 0111
    run_dut(1, 1, 1, 1'b0, 5'd5, 4'b0111, NO_EDGE, NO_EDGE);
    // stuck-1: wrong on the eleven vectors with < 3 ones, first is 0000
    run_dut(1, 1, 2, 1'b0, 5'd11, 4'b0000, NO_EDGE, NO_EDGE);
    // OR voter: wrong on the ten vectors with one or two ones, first is 0001
    run_dut(1, 1, 3, 1'b0, 5'd10, 4'b0001, NO_EDGE, NO_EDGE);
    // SETTLE=3, correct voter, stray start at E10 must be ignored
    run_dut(3, 3, 0, 1'b1, 5'd0, 4'd0, 10, NO_EDGE);
    // stuck-1 run aborted by reset at E9, then a full stuck-1 run
    run_dut(1, 1, 2, 1'b0, 5'd11, 4'b0000, NO_EDGE, 9);
    run_dut(1, 1, 2, 1'b0, 5'd11, 4'b0000, NO_EDGE, NO_EDGE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/majority_bist.md
# majority_bist

Built-in self-test sequencer for the 4-input majority voter. On `start` it drives all 16 input vectors into the voter in ascending order. After a programmable settle time it samples the voter output and checks it against a golden threshold function. It reports pass/fail, a mismatch count and the first failing vector. It sits beside the voter instance and owns its `a`/`b`/`c`/`d` inputs while a test runs.

## Interface
Parameters:
- `SETTLE`, default 1: cycles a vector is held before the voter output is sampled; legal range 1..15.
- `THRESH`, default 3: golden rule; expected output is 1 iff popcount({a,b,c,d}) >= THRESH.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test run; sampled only in IDLE.
- `dut_out`  in  1  voter output.
- `a`, `b`, `c`, `d`  out  1 each  voter inputs, registered.
- `busy`  out  1  high in APPLY and CHECK.
- `done`  out  1  one-cycle pulse, high in DONE.
- `pass`  out  1  1 iff the last completed run had zero mismatches.
- `fail_count`  out  5  mismatches in the last/current run, 0..16.
- `first_fail_vec`  out  4  {a,b,c,d} of the first mismatch; 0 if none.

## Operation
- State machine states:
  - IDLE: `a`..`d` = 0.
    - `start` = 1 → APPLY, with index = 0, settle counter = 0, `fail_count` = 0, `first_fail_vec` = 0, `pass` = 0.
    - `start` = 0 → stay in IDLE; results from the previous run are held.
  - APPLY: drives {a,b,c,d} = index, with `a` as MSB.
    - The settle counter increments each cycle.
    - When the counter reaches SETTLE-1 → CHECK.
  - CHECK: `a`..`d` keep driving the index.
    - Expected value = (popcount(index) >= THRESH).
    - On mismatch with `dut_out`: `fail_count` += 1. If `fail_count` was 0, `first_fail_vec` = index.
    - index = 15 → DONE. Otherwise index += 1, counter = 0, → APPLY.
  - DONE: `done` = 1, `a`..`d` = 0.
    - `pass` = (`fail_count` == 0), registered on entry to DONE.
    - Next state is IDLE unconditionally.
- Index is 4 bits; the run terminates on index = 15 in CHECK and never wraps.
- `start` is ignored in APPLY, CHECK and DONE. There is no queuing.
- `fail_count` saturates naturally at 16; its 5-bit width makes overflow impossible.
- `dut_out` is treated as combinational from `a`..`d`. SETTLE absorbs any voter pipelining, so `dut_out` must be valid SETTLE cycles after the vector changes.

## Timing
- Reset values:
  - state = IDLE.
  - `a` = `b` = `c` = `d` = 0, `busy` = 0, `done` = 0, `pass` = 0.
  - `fail_count` = 0, `first_fail_vec` = 0, index = 0, settle counter = 0.
- Cycle numbering: call the edge that samples `start` in IDLE E0.
  - Vector i is driven from edge E0 + i·(SETTLE+1).
  - Vector i is compared at edge E0 + (i+1)·(SETTLE+1).
- `done` is high for exactly one cycle, from edge E0 + 16·(SETTLE+1) to the next edge; with SETTLE = 1, that is E32 to E33.
- `busy` is high from E0 to E0 + 16·(SETTLE+1).
- The earliest back-to-back `start` is accepted at E0 + 16·(SETTLE+1) + 1.
- `pass`, `fail_count` and `first_fail_vec` are final and stable while `done` = 1, and are held until the next accepted `start`.
- Reset asserted mid-run forces all reset values on the next edge, aborting the run. `start` held high through reset deassertion begins a run on the first edge where `reset` = 0.

## Test plan
- Correct voter (out = popcount >= 3), SETTLE = 1, start pulse at E0:
  - `a`..`d` step 0000..1111, each held 2 cycles.
  - `done` pulses at E32; `pass` = 1, `fail_count` = 0, `first_fail_vec` = 0.
- `dut_out` tied 0 → `pass` = 0, `fail_count` = 5, `first_fail_vec` = 4'b0111.
- `dut_out` tied 1 → `fail_count` = 11, `first_fail_vec` = 4'b0000.
- Voter replaced by the 4-input OR → `fail_count` = 10, `first_fail_vec` = 4'b0001.
- SETTLE = 3, correct voter:
  - each vector is held 4 cycles and `done` pulses at E64.
  - a `start` pulse at E10 is ignored, and the run still ends with `pass` = 1.
- Reset at E9 during a `dut_out` = 1 run:
  - at E10 all outputs are at their reset values and the state is IDLE.
  - a new `start` gives a full run with `fail_count` = 11.
